// File: rtl/vram_port_arbiter_pkg.sv
// Shared constants for the VRAM port arbiter: MCU command codes and the
// per-cycle memory grant encoding.
package vram_port_arbiter_pkg;

    localparam logic [7:0] CMD_SET_ADDRESS = 8'h02;

    typedef enum logic [1:0] {
        GRANT_IDLE  = 2'd0,
        GRANT_READ  = 2'd1,
        GRANT_WRITE = 2'd2
    } grant_e;

endpackage

// File: rtl/vram_write_fifo.sv
// Synchronous write FIFO holding {address, data} entries for the MCU write path.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module vram_write_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [PW:0]      level
);

    localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PW:0]      wr_idx;
    logic [PW:0]      rd_idx;
    logic             push_ok;
    logic             pop_ok;

    assign level   = wr_idx - rd_idx;
    assign full    = (level == DEPTH_CNT);
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = storage[rd_idx[PW-1:0]];

    // NOTE: the storage array has no reset; the pointers alone define validity,
    // and leaving it unreset lets it map onto plain RAM cells.
    always_ff @(posedge sysclk) begin
        if (push_ok) storage[wr_idx[PW-1:0]] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
        end else begin
            if (push_ok) wr_idx <= wr_idx + 1'b1;
            if (pop_ok)  rd_idx <= rd_idx + 1'b1;
        end
    end

endmodule

// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: display scan-out reads always win, buffered MCU
// writes drain in FIFO order whenever the display is not reading.
module vram_port_arbiter
    import vram_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 19,
    parameter int FIFO_DEPTH = 4,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  sysclk,
    input  logic                  rst_n,
    input  logic                  cmdclk,
    input  logic [7:0]            cmd_code,
    input  logic [31:0]           cmd_address,
    input  logic                  dataclk,
    input  logic [7:0]            data_in,
    input  logic                  disp_req,
    input  logic [ADDR_WIDTH-1:0] disp_addr,
    output logic                  disp_valid,
    output logic [7:0]            disp_data,
    output logic                  mem_ce,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    output logic [LW-1:0]         fifo_level,
    output logic                  overflow
);

    localparam int EW = ADDR_WIDTH + 8;

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] base_ptr;
    logic                  set_addr;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [EW-1:0]         fifo_head;
    logic [1:0]            rd_pipe;
    grant_e                state_q;
    grant_e                state_d;
    logic                  unused_cmd_bits;

    assign unused_cmd_bits = ^cmd_address;

    // A SET_ADDRESS in the same cycle as a data strobe redirects that byte.
    assign set_addr  = cmdclk && (cmd_code == CMD_SET_ADDRESS);
    assign base_ptr  = set_addr ? cmd_address[ADDR_WIDTH-1:0] : wptr;
    assign fifo_push = dataclk && !fifo_full;
    assign fifo_pop  = !disp_req && !fifo_empty;

    vram_write_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sysclk    (sysclk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({base_ptr, data_in}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            overflow <= 1'b0;
        end else begin
            wptr <= dataclk ? base_ptr + ADDR_WIDTH'(1) : base_ptr;
            // The drop check comes last so a drop after a same-cycle clear still sticks.
            if (set_addr)               overflow <= 1'b0;
            if (dataclk && fifo_full)   overflow <= 1'b1;
        end
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = GRANT_IDLE;
        if (disp_req)         state_d = GRANT_READ;
        else if (!fifo_empty) state_d = GRANT_WRITE;
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) state_q <= GRANT_IDLE;
        else        state_q <= state_d;
    end

    assign mem_ce = (state_q != GRANT_IDLE);
    assign mem_we = (state_q == GRANT_WRITE);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state_d)
                GRANT_READ: mem_addr <= disp_addr;
                GRANT_WRITE: begin
                    mem_addr  <= fifo_head[EW-1:8];
                    mem_wdata <= fifo_head[7:0];
                end
                default: ;
            endcase
        end
    end

    // rd_pipe[0]: read on the VRAM port this cycle; rd_pipe[1]: its data on mem_rdata.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pipe    <= '0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
        end else begin
            rd_pipe    <= {rd_pipe[0], disp_req};
            disp_valid <= rd_pipe[1];
            if (rd_pipe[1]) disp_data <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: a queue-based transaction model of
// the write path and read latency, directed scenarios plus randomized traffic.
module tb_vram_port_arbiter;

    localparam int AW    = 19;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct { logic [AW-1:0] a; logic [7:0] d; } ent_t;
    typedef struct { int due; logic [7:0] d; } rd_t;

    logic          sysclk = 1'b0;
    logic          rst_n;
    logic          cmdclk;
    logic [7:0]    cmd_code;
    logic [31:0]   cmd_address;
    logic          dataclk;
    logic [7:0]    data_in;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_valid;
    logic [7:0]    disp_data;
    logic          mem_ce;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic [LW-1:0] fifo_level;
    logic          overflow;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int valid_cnt    = 0;
    int last_rd_cyc  = -1;

    ent_t          m_q[$];
    rd_t           m_pend[$];
    logic [AW-1:0] m_wptr;
    logic          m_ovf;
    logic          e_ce, e_we;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_wdata;

    logic [AW-1:0] wlog_a[$];
    logic [7:0]    wlog_d[$];
    int            wlog_c[$];

    vram_port_arbiter #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .cmdclk      (cmdclk),
        .cmd_code    (cmd_code),
        .cmd_address (cmd_address),
        .dataclk     (dataclk),
        .data_in     (data_in),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_valid  (disp_valid),
        .disp_data   (disp_data),
        .mem_ce      (mem_ce),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .fifo_level  (fifo_level),
        .overflow    (overflow)
    );

    always #5 sysclk = ~sysclk;

    function automatic logic [7:0] rd_pattern(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'hC3;
    endfunction

    // VRAM macro: read data appears the cycle after a read cycle; writes are logged.
    always @(posedge sysclk) begin
        if (mem_ce && !mem_we) begin
            mem_rdata   <= rd_pattern(mem_addr);
            last_rd_cyc <= cyc;
        end
        if (mem_ce && mem_we) begin
            wlog_a.push_back(mem_addr);
            wlog_d.push_back(mem_wdata);
            wlog_c.push_back(cyc);
        end
    end

    task automatic model_clear();
        m_q.delete();
        m_pend.delete();
        m_wptr  = '0;
        m_ovf   = 1'b0;
        e_ce    = 1'b0;
        e_we    = 1'b0;
        e_addr  = '0;
        e_wdata = '0;
    endtask

    task automatic log_clear();
        wlog_a.delete();
        wlog_d.delete();
        wlog_c.delete();
    endtask

    // One clock of stimulus; the model predicts the post-edge outputs and they are compared.
    task automatic tick(input logic c, input logic [7:0] code, input logic [31:0] ca,
                        input logic d, input logic [7:0] din,
                        input logic r, input logic [AW-1:0] ra);
        ent_t          h;
        logic          pop, full0, set, exp_v;
        logic [AW-1:0] base;
        logic [7:0]    exp_d;
        cmdclk = c; cmd_code = code; cmd_address = ca;
        dataclk = d; data_in = din; disp_req = r; disp_addr = ra;
        full0 = (m_q.size() == DEPTH);
        pop   = !r && (m_q.size() != 0);
        set   = c && (code == 8'h02);
        base  = set ? ca[AW-1:0] : m_wptr;
        e_ce  = r || pop;
        e_we  = pop;
        if (r) e_addr = ra;
        else if (pop) begin
            h = m_q.pop_front();
            e_addr  = h.a;
            e_wdata = h.d;
        end
        if (set) m_ovf = 1'b0;
        if (d) begin
            if (full0) m_ovf = 1'b1;
            else       m_q.push_back('{base, din});
            m_wptr = base + 1'b1;
        end else begin
            m_wptr = base;
        end
        @(posedge sysclk); #1;
        cyc++;
        if (r) m_pend.push_back('{cyc + 2, rd_pattern(ra)});
        exp_v = (m_pend.size() != 0) && (m_pend[0].due == cyc);
        exp_d = exp_v ? m_pend[0].d : 8'h00;
        if (exp_v) void'(m_pend.pop_front());
        if (disp_valid) valid_cnt++;

        tests_run++;
        if (mem_ce !== e_ce) begin
            tests_failed++;
            $display("FAIL mem_ce cyc=%0d got=%b exp=%b", cyc, mem_ce, e_ce);
        end
        tests_run++;
        if (mem_we !== e_we) begin
            tests_failed++;
            $display("FAIL mem_we cyc=%0d got=%b exp=%b", cyc, mem_we, e_we);
        end
        if (e_ce) begin
            tests_run++;
            if (mem_addr !== e_addr) begin
                tests_failed++;
                $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, e_addr);
            end
        end
        if (e_we) begin
            tests_run++;
            if (mem_wdata !== e_wdata) begin
                tests_failed++;
                $display("FAIL mem_wdata cyc=%0d got=%h exp=%h", cyc, mem_wdata, e_wdata);
            end
        end
        tests_run++;
        if (disp_valid !== exp_v) begin
            tests_failed++;
            $display("FAIL disp_valid cyc=%0d got=%b exp=%b", cyc, disp_valid, exp_v);
        end
        if (exp_v) begin
            tests_run++;
            if (disp_data !== exp_d) begin
                tests_failed++;
                $display("FAIL disp_data cyc=%0d got=%h exp=%h", cyc, disp_data, exp_d);
            end
        end
        tests_run++;
        if (fifo_level !== LW'(m_q.size())) begin
            tests_failed++;
            $display("FAIL fifo_level cyc=%0d got=%0d exp=%0d", cyc, fifo_level, m_q.size());
        end
        tests_run++;
        if (overflow !== m_ovf) begin
            tests_failed++;
            $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, overflow, m_ovf);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 1'b0, '0);
    endtask

    task automatic set_address(input logic [31:0] a, input logic r);
        tick(1'b1, 8'h02, a, 1'b0, 8'h00, r, '0);
    endtask

    task automatic push_byte(input logic [7:0] b, input logic r, input logic [AW-1:0] ra);
        tick(1'b0, 8'h00, 32'h0, 1'b1, b, r, ra);
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        tick(1'b0, 8'h00, 32'h0, 1'b1, 8'h9A, 1'b1, 19'd5);
        tick(1'b0, 8'h00, 32'h0, 1'b1, 8'h9B, 1'b1, 19'd6);
        #3 rst_n = 1'b0;
        #1;
        outs = {mem_ce, mem_we, disp_valid, overflow, |mem_addr, |mem_wdata, |disp_data, |fifo_level};
        tests_run++;
        if (outs !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_outputs got=%b exp=%b", outs, 8'h00);
        end
        model_clear();
        repeat (2) @(posedge sysclk);
        #1 rst_n = 1'b1;
        log_clear();
        idle(6);
        tests_run++;
        if (wlog_a.size() != 0) begin
            tests_failed++;
            $display("FAIL reset_flush writes=%0d exp=0", wlog_a.size());
        end
    endtask

    task automatic test_addr_data();
        log_clear();
        set_address(32'h0000_0100, 1'b0);
        push_byte(8'hAA, 1'b0, '0);
        push_byte(8'hBB, 1'b0, '0);
        idle(4);
        tests_run++;
        if (wlog_a.size() != 2 || wlog_a[0] !== 19'h100 || wlog_d[0] !== 8'hAA ||
            wlog_a[1] !== 19'h101 || wlog_d[1] !== 8'hBB || wlog_c[1] != wlog_c[0] + 1) begin
            tests_failed++;
            $display("FAIL addr_data n=%0d got0=%h/%h exp0=100/aa", wlog_a.size(),
                     wlog_a.size() > 0 ? wlog_a[0] : '0, wlog_d.size() > 0 ? wlog_d[0] : 8'h0);
        end
    endtask

    task automatic test_wrap();
        log_clear();
        set_address(32'h0007_FFFF, 1'b0);
        push_byte(8'h01, 1'b0, '0);
        push_byte(8'h02, 1'b0, '0);
        idle(4);
        tests_run++;
        if (wlog_a.size() != 2 || wlog_a[0] !== 19'h7FFFF || wlog_a[1] !== 19'h00000) begin
            tests_failed++;
            $display("FAIL wrap n=%0d got=%h,%h exp=7ffff,00000", wlog_a.size(),
                     wlog_a.size() > 0 ? wlog_a[0] : '0, wlog_a.size() > 1 ? wlog_a[1] : '0);
        end
    endtask

    task automatic test_priority_latency();
        int v0;
        log_clear();
        set_address(32'h0000_0040, 1'b0);
        v0 = valid_cnt;
        for (int i = 0; i < 10; i++) begin
            if (i < 3) push_byte(8'h11 * (i + 1), 1'b1, AW'(i));
            else       tick(1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 1'b1, AW'(i));
        end
        idle(6);
        tests_run++;
        if (valid_cnt - v0 != 10) begin
            tests_failed++;
            $display("FAIL prio_valid_count got=%0d exp=10", valid_cnt - v0);
        end
        tests_run++;
        if (wlog_a.size() != 3 || wlog_a[0] !== 19'h40 || wlog_a[2] !== 19'h42 ||
            wlog_d[0] !== 8'h11 || wlog_d[2] !== 8'h33 || wlog_c[0] <= last_rd_cyc) begin
            tests_failed++;
            $display("FAIL prio_write_order n=%0d first_wr_cyc=%0d last_rd_cyc=%0d", wlog_a.size(),
                     wlog_c.size() > 0 ? wlog_c[0] : -1, last_rd_cyc);
        end
    endtask

    task automatic test_overflow();
        log_clear();
        set_address(32'h0000_1000, 1'b1);
        for (int i = 0; i < 5; i++) push_byte(8'hE0 + 8'(i), 1'b1, AW'(i));
        tests_run++;
        if (fifo_level !== LW'(4) || overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_full level=%0d ovf=%b exp level=4 ovf=1", fifo_level, overflow);
        end
        idle(6);
        push_byte(8'h77, 1'b0, '0);
        idle(3);
        tests_run++;
        if (wlog_a.size() != 5 || wlog_a[4] !== 19'h1005 || wlog_d[4] !== 8'h77) begin
            tests_failed++;
            $display("FAIL overflow_next_addr n=%0d got=%h exp=01005", wlog_a.size(),
                     wlog_a.size() > 0 ? wlog_a[wlog_a.size()-1] : '0);
        end
        set_address(32'h0000_0300, 1'b0);
        tests_run++;
        if (overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL overflow_clear got=%b exp=0", overflow);
        end
    endtask

    task automatic test_collision();
        log_clear();
        tick(1'b1, 8'h02, 32'h0000_0200, 1'b1, 8'h55, 1'b0, '0);
        push_byte(8'h56, 1'b0, '0);
        idle(3);
        tests_run++;
        if (wlog_a.size() != 2 || wlog_a[0] !== 19'h200 || wlog_d[0] !== 8'h55 ||
            wlog_a[1] !== 19'h201) begin
            tests_failed++;
            $display("FAIL collision n=%0d got=%h exp=00200,00201", wlog_a.size(),
                     wlog_a.size() > 0 ? wlog_a[0] : '0);
        end
    endtask

    task automatic test_random();
        logic          r = 1'b0;
        logic [31:0]   a;
        logic [7:0]    code;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) r = ~r;
            a    = $urandom;
            code = ($urandom_range(0, 1) == 0) ? 8'h02 : 8'($urandom);
            tick($urandom_range(0, 15) == 0, code, a,
                 $urandom_range(0, 2) == 0, 8'($urandom), r, AW'($urandom));
        end
        idle(8);
    endtask

    initial begin
        rst_n = 1'b0;
        cmdclk = 1'b0; cmd_code = '0; cmd_address = '0;
        dataclk = 1'b0; data_in = '0; disp_req = 1'b0; disp_addr = '0;
        mem_rdata = '0;
        model_clear();
        repeat (2) @(posedge sysclk);
        #1 rst_n = 1'b1;
        test_reset();
        test_addr_data();
        test_wrap();
        test_priority_latency();
        test_overflow();
        test_collision();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
